// File: rtl/codec_i2c_sequencer_if.sv
// Request/response bus between the codec I2C sequencer and the byte-level I2C engine.
//
// Handshake: a request transfers on a rising clock edge where i2c_req_valid
// and i2c_req_ready are both high. Once raised, i2c_req_valid stays high and
// rnw/dev_addr/word stay stable until that transfer. i2c_rsp_valid is a
// one-cycle pulse with no ready; rsp_nack and rsp_data count only in that cycle.
// i2c_abort is a one-cycle pulse telling the engine to drop the bus and issue STOP.
interface codec_i2c_sequencer_if;
  logic        i2c_req_valid;
  logic        i2c_req_ready;
  logic        i2c_req_rnw;
  logic [6:0]  i2c_req_dev_addr;
  logic [15:0] i2c_req_word;
  logic        i2c_rsp_valid;
  logic        i2c_rsp_nack;
  logic [15:0] i2c_rsp_data;
  logic        i2c_abort;

  modport master (
    output i2c_req_valid, i2c_req_rnw, i2c_req_dev_addr, i2c_req_word, i2c_abort,
    input  i2c_req_ready, i2c_rsp_valid, i2c_rsp_nack, i2c_rsp_data
  );

  modport slave (
    input  i2c_req_valid, i2c_req_rnw, i2c_req_dev_addr, i2c_req_word, i2c_abort,
    output i2c_req_ready, i2c_rsp_valid, i2c_rsp_nack, i2c_rsp_data
  );
endinterface

// File: rtl/codec_i2c_sequencer.sv
// Codec I2C sequencer. It turns the register-block request bits into a single
// engine request, retries NACKed attempts after a gap and aborts on timeout.
// It then pulses the matching hw-clear and keeps the read data and status for sw.
module codec_i2c_sequencer #(
  parameter logic [6:0] DEV_ADDR       = 7'h1A,
  parameter int         MAX_RETRIES    = 3,
  parameter int         RETRY_GAP      = 64,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        axi_clk,
  input  logic        axi_reset,
  input  logic        codec_i2c_data_wr,
  input  logic        codec_i2c_data_rd,
  input  logic [31:0] codec_i2c_addr,
  input  logic [31:0] codec_i2c_wr_data,
  output logic        clear_codec_i2c_data_wr,
  output logic        clear_codec_i2c_data_rd,
  output logic [31:0] codec_i2c_rd_data,
  output logic [31:0] codec_i2c_status,
  output logic [2:0]  fsm_state,
  codec_i2c_sequencer_if.master bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = $clog2(RETRY_GAP + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(RETRY_GAP - 1);
  localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_BACKOFF = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          op_rd;
  logic [6:0]    addr_q;
  logic [8:0]    data_q;
  logic [8:0]    rd_data_q;
  logic          busy, nack_err, timeout;
  logic [3:0]    retry_cnt;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap;
  logic          can_retry;
  logic          unused_bits;

  assign can_retry = (retry_cnt < RETRY_MAX);
  assign fsm_state = state;
  assign codec_i2c_rd_data = {23'b0, rd_data_q};
  assign codec_i2c_status  = {24'b0, retry_cnt, 1'b0, timeout, nack_err, busy};
  assign unused_bits = ^{codec_i2c_addr[31:7], codec_i2c_wr_data[31:9], bus.i2c_rsp_data[15:9]};

  // State register; reset drops any transaction without a clear pulse or abort.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state decode and all FSM-driven outputs.
  always_comb begin
    state_nxt               = state;
    bus.i2c_req_valid       = 1'b0;
    bus.i2c_req_rnw         = 1'b0;
    bus.i2c_req_dev_addr    = 7'h00;
    bus.i2c_req_word        = 16'h0000;
    bus.i2c_abort           = 1'b0;
    clear_codec_i2c_data_wr = 1'b0;
    clear_codec_i2c_data_rd = 1'b0;
    case (state)
      S_IDLE: begin
        if (codec_i2c_data_wr || codec_i2c_data_rd) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        bus.i2c_req_valid    = 1'b1;
        bus.i2c_req_rnw      = op_rd;
        bus.i2c_req_dev_addr = DEV_ADDR;
        bus.i2c_req_word     = op_rd ? {addr_q, 1'b0, 8'h00} : {addr_q, data_q};
        if (bus.i2c_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A response arriving in the timeout cycle takes priority over the abort.
        if (bus.i2c_rsp_valid) begin
          if (bus.i2c_rsp_nack && can_retry) state_nxt = S_BACKOFF;
          else                               state_nxt = S_DONE;
        end else if (timer == TIMER_LAST) begin
          bus.i2c_abort = 1'b1;
          state_nxt     = S_DONE;
        end
      end
      S_BACKOFF: begin
        if (gap == GAP_LAST) state_nxt = S_ISSUE;
      end
      S_DONE: begin
        clear_codec_i2c_data_wr = !op_rd;
        clear_codec_i2c_data_rd = op_rd;
        state_nxt               = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latched request, timers, read data and status flags.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      op_rd     <= 1'b0;
      addr_q    <= 7'h00;
      data_q    <= 9'h000;
      rd_data_q <= 9'h000;
      busy      <= 1'b0;
      nack_err  <= 1'b0;
      timeout   <= 1'b0;
      retry_cnt <= 4'h0;
      timer     <= '0;
      gap       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (codec_i2c_data_wr || codec_i2c_data_rd) begin
            op_rd     <= !codec_i2c_data_wr;
            addr_q    <= codec_i2c_addr[6:0];
            data_q    <= codec_i2c_wr_data[8:0];
            nack_err  <= 1'b0;
            timeout   <= 1'b0;
            retry_cnt <= 4'h0;
            busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.i2c_req_ready) timer <= '0;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (bus.i2c_rsp_valid) begin
            if (!bus.i2c_rsp_nack) begin
              if (op_rd) rd_data_q <= bus.i2c_rsp_data[8:0];
            end else if (can_retry) begin
              retry_cnt <= retry_cnt + 1'b1;
              gap       <= '0;
            end else begin
              nack_err <= 1'b1;
            end
          end else if (timer == TIMER_LAST) begin
            timeout <= 1'b1;
          end
        end
        S_BACKOFF: gap <= gap + 1'b1;
        S_DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_i2c_sequencer.sv
// Directed bench for codec_i2c_sequencer with a hand-driven I2C engine and register block.
module tb_codec_i2c_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_bit, rd_bit;
  logic [31:0] addr, wdata;
  logic        clr_wr, clr_rd;
  logic [31:0] rd_data, status;
  logic [2:0]  fsm;
  int          cyc = 0;
  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          abort_cnt = 0;
  int          hs_cnt = 0;
  logic [15:0] cap_word;
  logic        cap_rnw;
  logic [6:0]  cap_dev;
  logic [1:0]  exp_q[$];

  codec_i2c_sequencer_if bus ();

  codec_i2c_sequencer #(
    .DEV_ADDR(7'h1A), .MAX_RETRIES(3), .RETRY_GAP(64), .TIMEOUT_CYCLES(50)
  ) dut (
    .axi_clk(clk),
    .axi_reset(rst),
    .codec_i2c_data_wr(wr_bit),
    .codec_i2c_data_rd(rd_bit),
    .codec_i2c_addr(addr),
    .codec_i2c_wr_data(wdata),
    .clear_codec_i2c_data_wr(clr_wr),
    .clear_codec_i2c_data_rd(clr_rd),
    .codec_i2c_rd_data(rd_data),
    .codec_i2c_status(status),
    .fsm_state(fsm),
    .bus(bus)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every clear pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (clr_wr || clr_rd) begin
      if (exp_q.size() == 0) check("sb_unexpected_clear", {30'b0, clr_rd, clr_wr}, 0);
      else                   check("sb_clear", {30'b0, clr_rd, clr_wr}, {30'b0, exp_q.pop_front()});
    end
    if (bus.i2c_abort) abort_cnt++;
    if (bus.i2c_req_valid && bus.i2c_req_ready) hs_cnt++;
  end

  // Wait (bounded) for a request handshake cycle and capture its fields.
  task automatic wait_req(input string tag, output int hs_cyc);
    int n = 0;
    while (!(bus.i2c_req_valid && bus.i2c_req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check({tag, "_no_req"}, 0, 1);
    hs_cyc   = cyc;
    cap_word = bus.i2c_req_word;
    cap_rnw  = bus.i2c_req_rnw;
    cap_dev  = bus.i2c_req_dev_addr;
  endtask

  // Drive a one-cycle engine response after a delay.
  task automatic respond(input int delay, input logic nack, input logic [15:0] data);
    repeat (delay) @(negedge clk);
    bus.i2c_rsp_valid = 1'b1;
    bus.i2c_rsp_nack  = nack;
    bus.i2c_rsp_data  = data;
    @(negedge clk);
    bus.i2c_rsp_valid = 1'b0;
    bus.i2c_rsp_nack  = 1'b0;
    bus.i2c_rsp_data  = 16'h0000;
  endtask

  // Check the clear pulse of the DONE cycle, emulate the register-block hw-clear.
  task automatic finish_txn(input string tag, input logic [1:0] exp_clr);
    check(tag, {30'b0, clr_rd, clr_wr}, {30'b0, exp_clr});
    if (clr_wr) wr_bit = 1'b0;
    if (clr_rd) rd_bit = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_timeout(input string tag, input logic [1:0] code);
    int h;
    int n = 0;
    wait_req(tag, h);
    while (!bus.i2c_abort && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_abort_lat"}, cyc - h, 50);
    @(negedge clk);
    finish_txn({tag, "_clear"}, code);
    check({tag, "_status"}, status, 32'h4);
  endtask

  initial begin
    int h, h2, c0, hs0;
    rst = 1'b1; wr_bit = 1'b0; rd_bit = 1'b0; addr = '0; wdata = '0;
    bus.i2c_req_ready = 1'b1; bus.i2c_rsp_valid = 1'b0;
    bus.i2c_rsp_nack = 1'b0; bus.i2c_rsp_data = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.i2c_req_valid, 0);
    check("rst_status", status, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_clears", {30'b0, clr_rd, clr_wr}, 0);
    check("rst_abort", bus.i2c_abort, 0);
    check("rst_word", bus.i2c_req_word, 0);
    check("rst_fsm", fsm, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: plain write; upper register bits must be ignored
    exp_q.push_back(2'b01);
    addr = 32'h5A5A_0007; wdata = 32'hFFFF_FEA5; wr_bit = 1'b1; c0 = cyc;
    @(negedge clk);
    wait_req("t1_req", h);
    check("t1_issue_lat", h - c0, 1);
    check("t1_word", cap_word, 16'h0EA5);
    check("t1_rnw", cap_rnw, 0);
    check("t1_dev", cap_dev, 7'h1A);
    check("t1_busy", status, 32'h1);
    respond(10, 1'b0, 16'hFFFF);
    finish_txn("t1_clear", 2'b01);
    check("t1_status", status, 0);
    check("t1_rd_data", rd_data, 0);

    // 2: read with engine stalling ready
    exp_q.push_back(2'b10);
    bus.i2c_req_ready = 1'b0; addr = 32'h0000_0003; rd_bit = 1'b1;
    repeat (4) @(negedge clk);
    check("t2_hold_valid", bus.i2c_req_valid, 1);
    check("t2_hold_word", bus.i2c_req_word, 16'h0600);
    bus.i2c_req_ready = 1'b1;
    wait_req("t2_req", h);
    check("t2_rnw", cap_rnw, 1);
    check("t2_word", cap_word, 16'h0600);
    respond(5, 1'b0, 16'hFDF3);
    finish_txn("t2_clear", 2'b10);
    check("t2_rd_data", rd_data, 32'h1F3);
    check("t2_status", status, 0);

    // 3: engine always NACKs; inputs changed mid-transaction must not leak
    exp_q.push_back(2'b01);
    addr = 32'h11; wdata = 32'h1FF; wr_bit = 1'b1; hs0 = hs_cnt;
    wait_req("t3_req0", h);
    check("t3_word0", cap_word, 16'h23FF);
    respond(3, 1'b1, 16'h0000);
    addr = 32'h7F; wdata = 32'h0;
    for (int a = 1; a < 4; a++) begin
      wait_req("t3_req", h2);
      check("t3_gap", h2 - h, 68);
      check("t3_word", cap_word, 16'h23FF);
      h = h2;
      respond(3, 1'b1, 16'h0000);
    end
    finish_txn("t3_clear", 2'b01);
    check("t3_status", status, 32'h32);
    repeat (80) @(negedge clk);
    check("t3_attempts", hs_cnt - hs0, 4);

    // 4: write timeout, then read timeout keeps old read data
    exp_q.push_back(2'b01);
    addr = 32'h5; wdata = 32'h0; wr_bit = 1'b1;
    run_timeout("t4", 2'b01);
    exp_q.push_back(2'b10);
    addr = 32'h2; rd_bit = 1'b1;
    run_timeout("t4r", 2'b10);
    check("t4r_rd_data", rd_data, 32'h1F3);

    // 5: both bits at once: write first, then read
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    addr = 32'h0A; wdata = 32'h123; wr_bit = 1'b1; rd_bit = 1'b1;
    wait_req("t5_wr", h);
    check("t5_wr_rnw", cap_rnw, 0);
    check("t5_wr_word", cap_word, 16'h1523);
    respond(4, 1'b0, 16'h0055);
    finish_txn("t5_wr_clear", 2'b01);
    check("t5_rd_data_kept", rd_data, 32'h1F3);
    wait_req("t5_rd", h);
    check("t5_rd_rnw", cap_rnw, 1);
    check("t5_rd_word", cap_word, 16'h1400);
    respond(4, 1'b0, 16'h00AB);
    finish_txn("t5_rd_clear", 2'b10);
    check("t5_rd_data", rd_data, 32'hAB);

    // 6: reset while waiting for the engine, request restarts afterwards
    addr = 32'h1; wdata = 32'h2; wr_bit = 1'b1;
    wait_req("t6_req", h);
    repeat (3) @(negedge clk);
    check("t6_in_wait", fsm, 3'd2);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", bus.i2c_req_valid, 0);
    check("t6_rst_status", status, 0);
    check("t6_rst_rd_data", rd_data, 0);
    check("t6_rst_fsm", fsm, 0);
    rst = 1'b0;
    exp_q.push_back(2'b01);
    wait_req("t6_restart", h);
    check("t6_word", cap_word, 16'h0202);
    respond(2, 1'b0, 16'h0000);
    finish_txn("t6_clear", 2'b01);
    check("t6_status", status, 0);

    repeat (5) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("abort_total", abort_cnt, 2);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
